touch_region_decoder: RTL and testbench

Multi-region touch-panel hit decoder with per-region debounce. It samples the touch controller's coordinates on a selected phase of the 2-bit display clock counter and compares them against a runtime-writable table of NREG rectangles. It emits a debounced pressed level plus one-cycle press/release pulses per region, and a priority-encoded hit index for the UI logic. It sits between the touch controller interface and the menu/button logic, and generalises the single fixed-rectangle detector.

---
 rtl/touch_region_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_touch_region_decoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_region_decoder.sv
// Multi-region touch hit decoder: samples touch coordinates on one clcount phase,
// tests them against a writable rectangle table and debounces each region independently.
module touch_region_decoder #(
  parameter int         XW       = 10,
  parameter int         YW       = 9,
  parameter int         NREG     = 4,
  parameter int         DEB      = 3,
  parameter logic [1:0] CL_PHASE = 2'd1,
  parameter int         IW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      clcount,
  input  logic            touch_down,
  input  logic [XW-1:0]   tor_x,
  input  logic [YW-1:0]   tor_y,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic            wr_valid,
  input  logic [XW-1:0]   wr_x1,
  input  logic [XW-1:0]   wr_x2,
  input  logic [YW-1:0]   wr_y1,
  input  logic [YW-1:0]   wr_y2,
  output logic [NREG-1:0] pressed,
  output logic [NREG-1:0] press_pulse,
  output logic [NREG-1:0] release_pulse,
  output logic            hit_any,
  output logic [IW-1:0]   hit_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_PRESSED, S_REL} state_t;

  localparam logic [3:0] L_DEB = 4'(DEB);

  logic [NREG-1:0] r_valid;
  logic [XW-1:0]   r_x1 [NREG];
  logic [XW-1:0]   r_x2 [NREG];
  logic [YW-1:0]   r_y1 [NREG];
  logic [YW-1:0]   r_y2 [NREG];

  state_t          r_state    [NREG];
  logic [3:0]      r_cnt      [NREG];
  state_t          w_state_nx [NREG];
  logic [3:0]      w_cnt_nx   [NREG];
  logic [3:0]      w_cnt_inc  [NREG];

  logic            w_sample;
  logic [NREG-1:0] w_wr_sel;
  logic [NREG-1:0] w_inside;
  logic [NREG-1:0] w_press_nx;
  logic [NREG-1:0] w_rel_nx;
  logic [NREG-1:0] w_pressed_nx;
  logic            w_hit_any_nx;
  logic [IW-1:0]   w_hit_idx_nx;
  logic            w_found;

  logic [NREG-1:0] r_pressed;
  logic [NREG-1:0] r_press_pulse;
  logic [NREG-1:0] r_rel_pulse;
  logic            r_hit_any;
  logic [IW-1:0]   r_hit_idx;

  assign w_sample = enable && (clcount == CL_PHASE);

  always_comb begin
    w_wr_sel = '0;
    w_inside = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_wr_sel[i]  = wr_en && (wr_idx == IW'(i));
      w_inside[i]  = r_valid[i] && touch_down &&
                     (tor_x >= r_x1[i]) && (tor_x <= r_x2[i]) &&
                     (tor_y >= r_y1[i]) && (tor_y <= r_y2[i]);
      w_cnt_inc[i] = r_cnt[i] + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_valid[i] <= (i == 0);
        r_x1[i]    <= (i == 0) ? XW'(184) : '0;
        r_x2[i]    <= (i == 0) ? XW'(326) : '0;
        r_y1[i]    <= (i == 0) ? YW'(121) : '0;
        r_y2[i]    <= (i == 0) ? YW'(219) : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_wr_sel[i]) begin
          r_valid[i] <= wr_valid;
          r_x1[i]    <= wr_x1;
          r_x2[i]    <= wr_x2;
          r_y1[i]    <= wr_y1;
          r_y2[i]    <= wr_y2;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_state[i] <= w_state_nx[i];
        r_cnt[i]   <= w_cnt_nx[i];
      end
    end
  end

  // A write to a region overrides that region's sample in the same cycle.
  always_comb begin
    w_press_nx = '0;
    w_rel_nx   = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_state_nx[i] = r_state[i];
      w_cnt_nx[i]   = r_cnt[i];
      if (w_wr_sel[i]) begin
        w_state_nx[i] = S_IDLE;
        w_cnt_nx[i]   = '0;
      end else if (w_sample) begin
        unique case (r_state[i])
          S_IDLE: if (w_inside[i]) begin
            if (L_DEB == 4'd1) begin
              w_state_nx[i] = S_PRESSED;
              w_press_nx[i] = 1'b1;
            end else begin
              w_state_nx[i] = S_ARM;
              w_cnt_nx[i]   = 4'd1;
            end
          end
          S_ARM: if (w_inside[i]) begin
            if (w_cnt_inc[i] == L_DEB) begin
              w_state_nx[i] = S_PRESSED;
              w_cnt_nx[i]   = '0;
              w_press_nx[i] = 1'b1;
            end else begin
              w_cnt_nx[i]   = w_cnt_inc[i];
            end
          end else begin
            w_state_nx[i] = S_IDLE;
            w_cnt_nx[i]   = '0;
          end
          S_PRESSED: if (!w_inside[i]) begin
            if (L_DEB == 4'd1) begin
              w_state_nx[i] = S_IDLE;
              w_rel_nx[i]   = 1'b1;
            end else begin
              w_state_nx[i] = S_REL;
              w_cnt_nx[i]   = 4'd1;
            end
          end
          S_REL: if (!w_inside[i]) begin
            if (w_cnt_inc[i] == L_DEB) begin
              w_state_nx[i] = S_IDLE;
              w_cnt_nx[i]   = '0;
              w_rel_nx[i]   = 1'b1;
            end else begin
              w_cnt_nx[i]   = w_cnt_inc[i];
            end
          end else begin
            w_state_nx[i] = S_PRESSED;
            w_cnt_nx[i]   = '0;
          end
          default: begin
            w_state_nx[i] = S_IDLE;
            w_cnt_nx[i]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_pressed_nx = '0;
    w_hit_idx_nx = '0;
    w_found      = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_pressed_nx[i] = (w_state_nx[i] == S_PRESSED) || (w_state_nx[i] == S_REL);
      if (w_pressed_nx[i] && !w_found) begin
        w_hit_idx_nx = IW'(i);
        w_found      = 1'b1;
      end
    end
    w_hit_any_nx = |w_pressed_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pressed     <= '0;
      r_press_pulse <= '0;
      r_rel_pulse   <= '0;
      r_hit_any     <= 1'b0;
      r_hit_idx     <= '0;
    end else begin
      r_pressed     <= w_pressed_nx;
      r_press_pulse <= w_press_nx;
      r_rel_pulse   <= w_rel_nx;
      r_hit_any     <= w_hit_any_nx;
      r_hit_idx     <= w_hit_idx_nx;
    end
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_rel_pulse;
  assign hit_any       = r_hit_any;
  assign hit_idx       = r_hit_idx;

endmodule

// File: tb/tb_touch_region_decoder.sv
// Bench for touch_region_decoder: directed scenarios plus random touches and table
// writes, checked every cycle against a streak-counting reference model.
module tb_touch_region_decoder;

  localparam int NR = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  clcount;
  logic        touch_down;
  logic [9:0]  tor_x, wr_x1, wr_x2;
  logic [8:0]  tor_y, wr_y1, wr_y2;
  logic        wr_en, wr_valid;
  logic [1:0]  wr_idx;
  logic [3:0]  pressed, press_pulse, release_pulse;
  logic        hit_any;
  logic [1:0]  hit_idx;

  int n_cmp = 0;
  int n_err = 0;
  int pp_cnt = 0;
  int rp_cnt = 0;

  touch_region_decoder #(
    .XW(10), .YW(9), .NREG(NR), .DEB(DB), .CL_PHASE(2'd1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clcount(clcount),
    .touch_down(touch_down), .tor_x(tor_x), .tor_y(tor_y),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
    .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_y1(wr_y1), .wr_y2(wr_y2),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .hit_any(hit_any), .hit_idx(hit_idx)
  );

  always #5 clk = ~clk;

  // Reference: a region toggles its level after DB consecutive qualified samples
  // that disagree with it; a table write drops it to released silently.
  bit         m_valid [NR];
  logic [9:0] m_x1 [NR], m_x2 [NR];
  logic [8:0] m_y1 [NR], m_y2 [NR];
  bit         m_pr [NR];
  int         m_streak [NR];
  logic [3:0] e_pp, e_rp;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_valid[i]  = (i == 0);
      m_x1[i]     = (i == 0) ? 10'd184 : 10'd0;
      m_x2[i]     = (i == 0) ? 10'd326 : 10'd0;
      m_y1[i]     = (i == 0) ? 9'd121 : 9'd0;
      m_y2[i]     = (i == 0) ? 9'd219 : 9'd0;
      m_pr[i]     = 1'b0;
      m_streak[i] = 0;
    end
    e_pp = '0;
    e_rp = '0;
  endfunction

  function automatic void model_edge();
    bit qual, ins;
    if (reset) begin
      model_reset();
      return;
    end
    qual = enable && (clcount == 2'd1);
    e_pp = '0;
    e_rp = '0;
    for (int i = 0; i < NR; i++) begin
      if (wr_en && (int'(wr_idx) == i)) begin
        m_pr[i] = 1'b0;
        m_streak[i] = 0;
      end else if (qual) begin
        ins = m_valid[i] && touch_down && tor_x >= m_x1[i] && tor_x <= m_x2[i] &&
              tor_y >= m_y1[i] && tor_y <= m_y2[i];
        if (ins != m_pr[i]) begin
          m_streak[i]++;
          if (m_streak[i] == DB) begin
            m_pr[i] = ins;
            m_streak[i] = 0;
            if (ins) e_pp[i] = 1'b1;
            else     e_rp[i] = 1'b1;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
    end
    if (wr_en && int'(wr_idx) < NR) begin
      m_valid[wr_idx] = wr_valid;
      m_x1[wr_idx] = wr_x1;
      m_x2[wr_idx] = wr_x2;
      m_y1[wr_idx] = wr_y1;
      m_y2[wr_idx] = wr_y2;
    end
  endfunction

  function automatic logic [3:0] exp_pressed();
    logic [3:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_pr[i];
    return v;
  endfunction

  function automatic logic [1:0] exp_idx();
    for (int i = 0; i < NR; i++) if (m_pr[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pressed", 32'(pressed), 32'(exp_pressed()));
    chk("press_pulse", 32'(press_pulse), 32'(e_pp));
    chk("release_pulse", 32'(release_pulse), 32'(e_rp));
    chk("hit_any", 32'(hit_any), 32'(|exp_pressed()));
    chk("hit_idx", 32'(hit_idx), 32'(exp_idx()));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    pp_cnt += int'(press_pulse[0]);
    rp_cnt += int'(release_pulse[0]);
    @(negedge clk);
    clcount = clcount + 2'd1;
  endtask

  task automatic samp(input int n);
    for (int k = 0; k < 4 * n; k++) cyc();
  endtask

  task automatic touch(input int x, input int y, input logic td);
    tor_x = 10'(x);
    tor_y = 9'(y);
    touch_down = td;
  endtask

  task automatic write_reg(input int idx, input logic v, input int x1, input int x2,
                           input int y1, input int y2);
    wr_en = 1'b1; wr_idx = 2'(idx); wr_valid = v;
    wr_x1 = 10'(x1); wr_x2 = 10'(x2); wr_y1 = 9'(y1); wr_y2 = 9'(y2);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clcount = 2'd0; touch_down = 1'b0;
    tor_x = '0; tor_y = '0; wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0;
    wr_x1 = '0; wr_x2 = '0; wr_y1 = '0; wr_y2 = '0;
    model_reset();
    @(negedge clk);
    cyc(); cyc();
    chk("reset_pressed", 32'(pressed), 32'd0);
    chk("reset_hit_any", 32'(hit_any), 32'd0);
    reset = 1'b0;
    clcount = 2'd0;

    // basic press in the default region
    pp_cnt = 0;
    touch(200, 150, 1'b1);
    samp(3);
    chk("press_pulse_once", 32'(pp_cnt), 32'd1);
    chk("press_level", 32'(pressed), 32'h1);
    chk("press_hit_idx", 32'(hit_idx), 32'd0);
    chk("press_hit_any", 32'(hit_any), 32'd1);

    // short dropout does not release, full dropout does
    rp_cnt = 0;
    touch(200, 150, 1'b0); samp(2);
    touch(200, 150, 1'b1); samp(1);
    chk("glitch_no_release", 32'(rp_cnt), 32'd0);
    chk("glitch_still_pressed", 32'(pressed), 32'h1);
    touch(200, 150, 1'b0); samp(3);
    chk("release_pulse_once", 32'(rp_cnt), 32'd1);
    chk("released_level", 32'(pressed), 32'h0);

    // inclusive boundaries
    touch(184, 121, 1'b1); samp(3);
    chk("corner_lo_hit", 32'(pressed), 32'h1);
    touch(0, 0, 1'b0); samp(3);
    touch(326, 219, 1'b1); samp(3);
    chk("corner_hi_hit", 32'(pressed), 32'h1);
    touch(0, 0, 1'b0); samp(3);
    touch(183, 150, 1'b1); samp(5);
    chk("x_below_miss", 32'(pressed), 32'h0);
    touch(200, 220, 1'b1); samp(5);
    chk("y_above_miss", 32'(pressed), 32'h0);
    touch(0, 0, 1'b0);

    // overlapping regions
    write_reg(2, 1'b1, 0, 50, 0, 50); cyc();
    write_reg(1, 1'b1, 0, 100, 0, 100); cyc();
    wr_en = 1'b0; cyc(); cyc();
    touch(10, 10, 1'b1); samp(3);
    chk("overlap_pressed", 32'(pressed), 32'h6);
    chk("overlap_hit_idx", 32'(hit_idx), 32'd1);
    touch(0, 0, 1'b0); samp(3);

    // rewrite a pressed region while a sample lands on the same edge
    touch(200, 150, 1'b1); samp(3);
    chk("pre_rewrite_pressed", 32'(pressed[0]), 32'd1);
    rp_cnt = 0; pp_cnt = 0;
    cyc();
    write_reg(0, 1'b1, 184, 326, 121, 219); cyc();
    wr_en = 1'b0; cyc(); cyc();
    chk("rewrite_cleared", 32'(pressed[0]), 32'd0);
    chk("rewrite_no_release", 32'(rp_cnt), 32'd0);
    chk("rewrite_no_press", 32'(pp_cnt), 32'd0);
    samp(3);
    chk("rewrite_repress", 32'(pp_cnt), 32'd1);
    chk("rewrite_pressed", 32'(pressed[0]), 32'd1);

    // async reset mid-debounce
    touch(0, 0, 1'b0); samp(3);
    touch(200, 150, 1'b1); samp(2);
    #2 reset = 1'b1;
    #1 model_reset();
    chk("async_rst_pressed", 32'(pressed), 32'd0);
    chk("async_rst_pp", 32'(press_pulse), 32'd0);
    chk("async_rst_rp", 32'(release_pulse), 32'd0);
    chk("async_rst_hit_any", 32'(hit_any), 32'd0);
    chk("async_rst_hit_idx", 32'(hit_idx), 32'd0);
    cyc();
    reset = 1'b0;
    clcount = 2'd0;
    samp(2);
    chk("post_rst_two_samples", 32'(pressed), 32'h0);
    samp(1);
    chk("post_rst_third_sample", 32'(pressed), 32'h1);

    // random touches, enables and table writes
    for (int k = 0; k < 80; k++) begin
      int r;
      r = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 1) == 0 && m_valid[r] && m_x1[r] <= m_x2[r] && m_y1[r] <= m_y2[r]) begin
        tor_x = 10'(int'(m_x1[r]) + $urandom_range(0, int'(m_x2[r]) - int'(m_x1[r])));
        tor_y = 9'(int'(m_y1[r]) + $urandom_range(0, int'(m_y2[r]) - int'(m_y1[r])));
      end else begin
        tor_x = 10'($urandom_range(0, 700));
        tor_y = 9'($urandom_range(0, 500));
      end
      touch_down = ($urandom_range(0, 9) != 0);
      for (int j = 0, hold = $urandom_range(4, 24); j < hold; j++) begin
        enable = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) begin
          int x1, y1;
          x1 = $urandom_range(0, 500);
          y1 = $urandom_range(0, 300);
          if ($urandom_range(0, 5) == 0 && x1 > 0)
            write_reg($urandom_range(0, NR - 1), 1'b1, x1, x1 - 1, y1, y1 + 10);
          else
            write_reg($urandom_range(0, NR - 1), ($urandom_range(0, 4) != 0),
                      x1, x1 + $urandom_range(0, 400), y1, y1 + $urandom_range(0, 200));
        end else begin
          wr_en = 1'b0;
        end
        cyc();
      end
    end
    wr_en = 1'b0;
    enable = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
